av2_fb_port_arbiter: RTL and testbench
======================================

Name: av2_fb_port_arbiter

Overview:
- Shares the single frame-buffer controller access port between three requesters: tile-decoder reference reads, output-controller reads, and tile-decoder reconstruction writes.
- Replaces static state-based muxing, so reference fetch, reconstruction write-back and frame output can overlap.
- Issues one request per accepted downstream handshake and tracks outstanding reads with a tag FIFO.
- Routes in-order read responses back to the originating reader.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 128, read/write data width
MAX_OUTSTANDING, 4, maximum reads issued but not yet returned (power of 2, at least 2)
WR_BURST_LIMIT, 8, maximum consecutive write grants while any read is eligible

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ref_req  in  1  reference read request; held with ref_addr until ref_gnt
ref_addr  in  ADDR_WIDTH  reference read address
ref_gnt  out  1  one-cycle pulse: ref request captured
ref_rvalid  out  1  reference read data valid
ref_rdata  out  DATA_WIDTH  reference read data
out_req  in  1  output read request; held with out_addr until out_gnt
out_addr  in  ADDR_WIDTH  output read address
out_gnt  out  1  one-cycle pulse: out request captured
out_rvalid  out  1  output read data valid
out_rdata  out  DATA_WIDTH  output read data
wr_req  in  1  write request; held with wr_addr and wr_data until wr_gnt
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_gnt  out  1  one-cycle pulse: write captured
mem_valid  out  1  downstream request valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  downstream address
mem_wdata  out  DATA_WIDTH  downstream write data
mem_ready  in  1  downstream accepts the request when mem_valid is also high
mem_rvalid  in  1  downstream read response, strictly in issue order
mem_rdata  in  DATA_WIDTH  downstream read data
busy  out  1  mem_valid high or outstanding count nonzero
err_unexp_rsp  out  1  sticky: mem_rvalid arrived with no read outstanding

Behaviour:
- Reset (async, rst_n=0): all outputs 0. Output stage, tag FIFO, outstanding count, write-burst counter cleared; round-robin pointer set to ref.
- Output stage: single register holding mem_valid, mem_we, mem_addr, mem_wdata.
  - Held stable while mem_valid && !mem_ready.
  - May load when empty or when mem_valid && mem_ready this cycle (zero-bubble back-to-back).
- Arbitration occurs only in cycles where the stage may load. At most one gnt pulse per cycle, asserted in the same cycle the stage loads.
- Read eligibility: reads eligible only if outstanding < MAX_OUTSTANDING.
  - outstanding increments on read capture into the stage.
  - outstanding decrements on response delivery.
  - Simultaneous capture and delivery leaves it unchanged.
- Priority:
  - wr_req wins unless the write-burst counter equals WR_BURST_LIMIT and a read is eligible; in that case the read wins.
  - The counter increments on each write grant made while a read is eligible and clears on any read grant. It also clears on any cycle with no eligible read.
  - Between reads: round-robin. The pointer names the preferred reader; after a read grant it moves to the other reader. A lone requester is granted regardless of the pointer.
- Tag FIFO: depth MAX_OUTSTANDING, 1-bit tag (0 = ref, 1 = out).
  - Push on read capture; pop on mem_rvalid.
  - It cannot overflow because of the outstanding limit.
- Response routing is registered: mem_rvalid at cycle N produces the tagged reader's rvalid and rdata at N+1.
  - The non-selected reader's rvalid is 0; its rdata holds its last value.
- mem_rvalid with an empty FIFO: data dropped, err_unexp_rsp set. Cleared only by reset.
- Write responses are not tracked. Writes and reads to the same address are ordered by issue order only.
- Latency from req to mem_valid: 1 cycle when the stage is free and the request wins.
- Reset mid-operation aborts all in-flight state. Later stray mem_rvalid sets err_unexp_rsp.

Test Plan:
- Single ref read at addr 0x100 with idle port -> ref_gnt same cycle, mem_valid/mem_we=0/mem_addr=0x100 next cycle. mem_rvalid with data 0xA5.. returned -> ref_rvalid=1 with that data one cycle later, out_rvalid stays 0.
- ref_req and out_req held continuously, mem_ready=1, responses returned after 3 cycles -> grants alternate ref, out, ref, out. Response tags match the alternation. outstanding never exceeds 4.
- mem_ready=0 with 4 reads issued and no responses -> no further read gnt. A concurrent wr_req is still granted once the stage frees. The first mem_rvalid releases exactly one read grant.
- wr_req held continuously plus ref_req, WR_BURST_LIMIT=8 -> 8 wr_gnt, then 1 ref_gnt, then 8 wr_gnt, repeating.
- mem_valid high with mem_ready low for 5 cycles -> mem_addr, mem_we and mem_wdata stable throughout, no gnt pulses. The accept cycle loads the next winner with no idle cycle.
- mem_rvalid pulse with nothing outstanding -> err_unexp_rsp=1 sticky, no rvalid. Assert rst_n=0 mid-traffic -> all outputs 0 immediately, busy=0.

Source files
------------

// File: rtl/av2_fb_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the frame-buffer port arbiter.
// The arbiter takes the slave view; the surrounding system takes the master view.
interface av2_fb_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128
);

  // Reference reader
  logic                  ref_req;
  logic [ADDR_WIDTH-1:0] ref_addr;
  logic                  ref_gnt;
  logic                  ref_rvalid;
  logic [DATA_WIDTH-1:0] ref_rdata;

  // Output-controller reader
  logic                  out_req;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_gnt;
  logic                  out_rvalid;
  logic [DATA_WIDTH-1:0] out_rdata;

  // Reconstruction writer
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_gnt;

  // Downstream frame-buffer controller port
  logic                  mem_valid;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Status
  logic                  busy;
  logic                  err_unexp_rsp;

  modport slave (
    input  ref_req, ref_addr, out_req, out_addr,
    input  wr_req, wr_addr, wr_data,
    input  mem_ready, mem_rvalid, mem_rdata,
    output ref_gnt, ref_rvalid, ref_rdata,
    output out_gnt, out_rvalid, out_rdata,
    output wr_gnt,
    output mem_valid, mem_we, mem_addr, mem_wdata,
    output busy, err_unexp_rsp
  );

  modport master (
    output ref_req, ref_addr, out_req, out_addr,
    output wr_req, wr_addr, wr_data,
    output mem_ready, mem_rvalid, mem_rdata,
    input  ref_gnt, ref_rvalid, ref_rdata,
    input  out_gnt, out_rvalid, out_rdata,
    input  wr_gnt,
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    input  busy, err_unexp_rsp
  );

endinterface

// File: rtl/av2_fb_port_arbiter.sv
// Shares the frame-buffer controller port between reference reads, output reads and
// reconstruction writes; tracks outstanding reads with a tag FIFO and routes responses back.
module av2_fb_port_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned WR_BURST_LIMIT  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  av2_fb_port_arbiter_if.slave    bus
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BST_W = $clog2(WR_BURST_LIMIT + 1);

  typedef enum logic {
    RD_REF = 1'b0,
    RD_OUT = 1'b1
  } rd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } stage_t;

  stage_t               stage_q, stage_d;
  logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [BST_W-1:0]     burst_q, burst_d;
  rd_sel_e              rr_q, rr_d;
  logic                 busy_q;
  logic                 err_q;
  logic                 ref_rvalid_q, out_rvalid_q;
  logic [DATA_WIDTH-1:0] ref_rdata_q, out_rdata_q;

  logic    can_load;
  logic    rd_elig;
  logic    wr_win;
  logic    gnt_wr;
  logic    gnt_rd;
  rd_sel_e rd_sel;
  logic    rsp_hit;
  logic    rsp_is_out;

  // Arbitration: writes win unless a full burst has starved an eligible read.
  always_comb begin
    can_load = !stage_q.valid || bus.mem_ready;
    rd_elig  = (bus.ref_req || bus.out_req) && (out_cnt_q < CNT_W'(MAX_OUTSTANDING));
    wr_win   = bus.wr_req && !((burst_q == BST_W'(WR_BURST_LIMIT)) && rd_elig);
    gnt_wr   = can_load && wr_win;
    gnt_rd   = can_load && rd_elig && !wr_win;
    if (bus.ref_req && bus.out_req) begin
      rd_sel = rr_q;
    end else if (bus.out_req) begin
      rd_sel = RD_OUT;
    end else begin
      rd_sel = RD_REF;
    end
    rsp_hit    = bus.mem_rvalid && (out_cnt_q != '0);
    rsp_is_out = tag_q[rd_ptr_q];
  end

  // Next-state for the output stage, FIFO pointers, counters and round-robin pointer.
  always_comb begin
    stage_d   = stage_q;
    out_cnt_d = out_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    burst_d   = burst_q;
    rr_d      = rr_q;

    if (can_load) begin
      stage_d.valid = gnt_wr || gnt_rd;
      if (gnt_wr) begin
        stage_d.we    = 1'b1;
        stage_d.addr  = bus.wr_addr;
        stage_d.wdata = bus.wr_data;
      end else if (gnt_rd) begin
        stage_d.we    = 1'b0;
        stage_d.addr  = (rd_sel == RD_REF) ? bus.ref_addr : bus.out_addr;
        stage_d.wdata = '0;
      end
    end

    if (gnt_rd) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      rr_d     = (rd_sel == RD_REF) ? RD_OUT : RD_REF;
    end
    if (rsp_hit) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (gnt_rd && !rsp_hit) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end else if (!gnt_rd && rsp_hit) begin
      out_cnt_d = out_cnt_q - 1'b1;
    end

    // Burst counter only measures writes that keep a ready read waiting.
    if (!rd_elig || gnt_rd) begin
      burst_d = '0;
    end else if (gnt_wr && (burst_q < BST_W'(WR_BURST_LIMIT))) begin
      burst_d = burst_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q   <= '0;
      out_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_q     <= '0;
      burst_q   <= '0;
      rr_q      <= RD_REF;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      out_cnt_q <= out_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      burst_q   <= burst_d;
      rr_q      <= rr_d;
      busy_q    <= stage_d.valid || (out_cnt_d != '0);
      if (gnt_rd) begin
        tag_q[wr_ptr_q] <= (rd_sel == RD_OUT);
      end
      if (bus.mem_rvalid && (out_cnt_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Response routing: one cycle behind mem_rvalid, steered by the oldest tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_rvalid_q <= 1'b0;
      out_rvalid_q <= 1'b0;
      ref_rdata_q  <= '0;
      out_rdata_q  <= '0;
    end else begin
      ref_rvalid_q <= rsp_hit && !rsp_is_out;
      out_rvalid_q <= rsp_hit && rsp_is_out;
      if (rsp_hit && !rsp_is_out) begin
        ref_rdata_q <= bus.mem_rdata;
      end
      if (rsp_hit && rsp_is_out) begin
        out_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Grants pulse in the cycle the stage captures; forced low while reset is held.
  assign bus.ref_gnt = rst_n && gnt_rd && (rd_sel == RD_REF);
  assign bus.out_gnt = rst_n && gnt_rd && (rd_sel == RD_OUT);
  assign bus.wr_gnt  = rst_n && gnt_wr;

  assign bus.mem_valid     = stage_q.valid;
  assign bus.mem_we        = stage_q.we;
  assign bus.mem_addr      = stage_q.addr;
  assign bus.mem_wdata     = stage_q.wdata;
  assign bus.ref_rvalid    = ref_rvalid_q;
  assign bus.ref_rdata     = ref_rdata_q;
  assign bus.out_rvalid    = out_rvalid_q;
  assign bus.out_rdata     = out_rdata_q;
  assign bus.busy          = busy_q;
  assign bus.err_unexp_rsp = err_q;

endmodule

// File: tb/tb_av2_fb_port_arbiter.sv
// Directed bench for av2_fb_port_arbiter: grant timing, round-robin, outstanding limit,
// write-burst fairness, stall stability, unexpected responses and async reset.
module tb_av2_fb_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  av2_fb_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) bus ();

  av2_fb_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(128), .MAX_OUTSTANDING(4), .WR_BURST_LIMIT(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  logic [127:0]  d_a5;
  logic          exp_out;
  int            model_out;
  logic [31:0]   ref_a, out_a, a;
  logic [31:0]   addr_q[$];
  int            due_q[$];
  logic          rsp_now, prev_v, prev_isout;
  logic [127:0]  prev_data;
  int            rsp_k;

  initial begin
    d_a5 = {16{8'hA5}};
    bus.ref_req = 0; bus.ref_addr = '0; bus.out_req = 0; bus.out_addr = '0;
    bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state
    to_neg();
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_gnts", {bus.ref_gnt, bus.out_gnt, bus.wr_gnt}, 0);
    chk("rst_rvalids", {bus.ref_rvalid, bus.out_rvalid}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err_unexp_rsp, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single reference read
    bus.ref_req = 1; bus.ref_addr = 32'h100; bus.mem_ready = 1;
    to_neg();
    chk("t2_ref_gnt", bus.ref_gnt, 1);
    chk("t2_out_gnt", bus.out_gnt, 0);
    chk("t2_wr_gnt", bus.wr_gnt, 0);
    chk("t2_valid_pre", bus.mem_valid, 0);
    tick();
    bus.ref_req = 0;
    to_neg();
    chk("t2_mem_valid", bus.mem_valid, 1);
    chk("t2_mem_we", bus.mem_we, 0);
    chk("t2_mem_addr", bus.mem_addr, 32'h100);
    chk("t2_ref_gnt_off", bus.ref_gnt, 0);
    chk("t2_busy", bus.busy, 1);
    tick();
    bus.mem_rvalid = 1; bus.mem_rdata = d_a5;
    to_neg();
    chk("t2_valid_post", bus.mem_valid, 0);
    chk("t2_busy_out", bus.busy, 1);
    chk("t2_rvalid_early", bus.ref_rvalid, 0);
    tick();
    bus.mem_rvalid = 0; bus.mem_rdata = '0;
    to_neg();
    chk("t2_ref_rvalid", bus.ref_rvalid, 1);
    chk("t2_ref_rdata", bus.ref_rdata, d_a5);
    chk("t2_out_rvalid", bus.out_rvalid, 0);
    tick();
    to_neg();
    chk("t2_rvalid_pulse", bus.ref_rvalid, 0);
    chk("t2_rdata_hold", bus.ref_rdata, d_a5);
    chk("t2_busy_idle", bus.busy, 0);

    // Both readers held, responses three cycles after acceptance
    exp_out = 1'b1;  // pointer moved to out after the ref grant above
    model_out = 0; ref_a = 32'h1000; out_a = 32'h2000; a = '0;
    prev_v = 0; prev_isout = 0; prev_data = '0;
    for (int c = 0; c < 45; c++) begin
      tick();
      bus.ref_req = (c < 30); bus.out_req = (c < 30);
      bus.ref_addr = ref_a; bus.out_addr = out_a;
      rsp_now = 0;
      if (due_q.size() > 0 && due_q[0] <= c) begin
        a = addr_q.pop_front();
        void'(due_q.pop_front());
        bus.mem_rvalid = 1; bus.mem_rdata = {a, ~a, 64'h0123_4567_89AB_CDEF};
        rsp_now = 1;
      end else begin
        bus.mem_rvalid = 0;
      end
      to_neg();
      chk("t3_ref_rvalid", bus.ref_rvalid, prev_v && !prev_isout);
      chk("t3_out_rvalid", bus.out_rvalid, prev_v && prev_isout);
      if (prev_v) chk("t3_rdata", prev_isout ? bus.out_rdata : bus.ref_rdata, prev_data);
      if (c < 30) chk("t3_rd_gnt", bus.ref_gnt | bus.out_gnt, model_out < 4);
      chk("t3_one_gnt", bus.ref_gnt & bus.out_gnt, 0);
      if (bus.ref_gnt | bus.out_gnt) begin
        chk("t3_alternate", bus.out_gnt, exp_out);
        exp_out = !exp_out;
        model_out++;
        if (bus.out_gnt) out_a += 32'h10; else ref_a += 32'h10;
      end
      if (bus.mem_valid && !bus.mem_we) begin
        addr_q.push_back(bus.mem_addr);
        due_q.push_back(c + 3);
      end
      if (rsp_now) model_out--;
      prev_v = rsp_now; prev_isout = a[13]; prev_data = {a, ~a, 64'h0123_4567_89AB_CDEF};
    end
    chk("t3_drained", bus.busy, 0);

    // Outstanding limit: four reads in flight block further reads, not writes
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.ref_req = 1; bus.ref_addr = 32'h4000 + 32'(i * 16);
      to_neg();
      chk("t4_ref_gnt_fill", bus.ref_gnt, 1);
    end
    tick();
    bus.ref_addr = 32'h4040; bus.mem_ready = 0;
    bus.wr_req = 1; bus.wr_addr = 32'h5000; bus.wr_data = 128'h5555;
    to_neg();
    chk("t4_stall_nognt", {bus.ref_gnt, bus.wr_gnt}, 0);
    chk("t4_stall_addr", bus.mem_addr, 32'h4030);
    tick();
    bus.mem_ready = 1;
    to_neg();
    chk("t4_wr_gnt", bus.wr_gnt, 1);
    chk("t4_ref_blocked", bus.ref_gnt, 0);
    tick();
    bus.wr_req = 0;
    to_neg();
    chk("t4_wr_issued", {bus.mem_valid, bus.mem_we}, 2'b11);
    chk("t4_wr_addr", bus.mem_addr, 32'h5000);
    chk("t4_wr_data", bus.mem_wdata, 128'h5555);
    chk("t4_ref_still_blocked", bus.ref_gnt, 0);
    tick();
    bus.mem_rvalid = 1; bus.mem_rdata = 128'h4000;
    to_neg();
    chk("t4_ref_blocked_rsp", bus.ref_gnt, 0);
    tick();
    bus.mem_rvalid = 0;
    to_neg();
    chk("t4_one_release", bus.ref_gnt, 1);
    chk("t4_rsp_rvalid", bus.ref_rvalid, 1);
    chk("t4_rsp_rdata", bus.ref_rdata, 128'h4000);
    tick();
    to_neg();
    chk("t4_refull", bus.ref_gnt, 0);
    chk("t4_fifth_addr", bus.mem_addr, 32'h4040);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.ref_req = 0; bus.mem_rvalid = 1; bus.mem_rdata = 128'(i + 1);
      to_neg();
    end
    tick();
    bus.mem_rvalid = 0;
    to_neg();
    chk("t4_drain_rdata", bus.ref_rdata, 128'h4);
    tick();
    to_neg();
    chk("t4_idle", {bus.busy, bus.err_unexp_rsp}, 0);

    // Stage held while mem_ready is low, then zero-bubble reload
    tick();
    bus.mem_ready = 0; bus.wr_req = 1; bus.wr_addr = 32'h3000; bus.wr_data = 128'hD1;
    to_neg();
    chk("t5_wr_gnt0", bus.wr_gnt, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        bus.wr_addr = 32'h3010; bus.wr_data = 128'hD2;
        bus.ref_req = 1; bus.ref_addr = 32'h1500;
      end
      to_neg();
      chk("t5_hold_valid", {bus.mem_valid, bus.mem_we}, 2'b11);
      chk("t5_hold_addr", bus.mem_addr, 32'h3000);
      chk("t5_hold_wdata", bus.mem_wdata, 128'hD1);
      chk("t5_hold_nognt", {bus.ref_gnt, bus.out_gnt, bus.wr_gnt}, 0);
    end
    tick();
    bus.mem_ready = 1;
    to_neg();
    chk("t5_accept_wr_gnt", bus.wr_gnt, 1);
    chk("t5_accept_ref", bus.ref_gnt, 0);
    tick();
    bus.wr_req = 0;
    to_neg();
    chk("t5_next_valid", bus.mem_valid, 1);
    chk("t5_next_addr", bus.mem_addr, 32'h3010);
    chk("t5_next_wdata", bus.mem_wdata, 128'hD2);
    chk("t5_ref_gnt", bus.ref_gnt, 1);
    tick();
    bus.ref_req = 0;
    to_neg();
    chk("t5_rd_issue", {bus.mem_valid, bus.mem_we}, 2'b10);
    chk("t5_rd_addr", bus.mem_addr, 32'h1500);
    tick();
    bus.mem_rvalid = 1; bus.mem_rdata = 128'hDB;
    to_neg();
    tick();
    bus.mem_rvalid = 0;
    to_neg();
    chk("t5_rsp", {bus.ref_rvalid, bus.ref_rdata[7:0]}, 9'h1DB);

    // Write burst fairness: 8 writes then 1 read, repeating
    rsp_k = -10;
    for (int k = 0; k < 31; k++) begin
      tick();
      bus.wr_req = (k < 27); bus.ref_req = (k < 27);
      bus.wr_addr = 32'h6000 + 32'(k); bus.ref_addr = 32'h7000 + 32'(k);
      bus.mem_rvalid = (k == rsp_k); bus.mem_rdata = 128'(k);
      to_neg();
      if (k < 27) begin
        chk("t6_wr_gnt", bus.wr_gnt, (k % 9) != 8);
        chk("t6_ref_gnt", bus.ref_gnt, (k % 9) == 8);
      end
      chk("t6_ref_rvalid", bus.ref_rvalid, k == rsp_k + 1);
      if (bus.ref_gnt) rsp_k = k + 2;
    end
    chk("t6_idle", bus.busy, 0);

    // Unexpected response with nothing outstanding
    tick();
    bus.mem_rvalid = 1; bus.mem_rdata = 128'hDEAD;
    to_neg();
    chk("t7_err_pre", bus.err_unexp_rsp, 0);
    tick();
    bus.mem_rvalid = 0;
    to_neg();
    chk("t7_err_set", bus.err_unexp_rsp, 1);
    chk("t7_no_rvalid", {bus.ref_rvalid, bus.out_rvalid}, 0);
    tick(); tick();
    to_neg();
    chk("t7_err_sticky", bus.err_unexp_rsp, 1);

    // Reset in the middle of traffic
    tick();
    bus.ref_req = 1; bus.out_req = 1; bus.ref_addr = 32'h8000; bus.out_addr = 32'h9000;
    to_neg();
    chk("t8_gnt", bus.ref_gnt | bus.out_gnt, 1);
    tick();
    to_neg();
    chk("t8_busy", bus.busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_rst_valid", bus.mem_valid, 0);
    chk("t8_rst_gnts", {bus.ref_gnt, bus.out_gnt, bus.wr_gnt}, 0);
    chk("t8_rst_busy", bus.busy, 0);
    chk("t8_rst_err", bus.err_unexp_rsp, 0);
    chk("t8_rst_rdata", bus.ref_rdata, 0);
    tick();
    bus.ref_req = 0; bus.out_req = 0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.mem_rvalid = 1; bus.mem_rdata = 128'hBAD;
    to_neg();
    tick();
    bus.mem_rvalid = 0;
    to_neg();
    chk("t8_stray_err", bus.err_unexp_rsp, 1);
    chk("t8_stray_rvalid", {bus.ref_rvalid, bus.out_rvalid}, 0);
    tick();
    bus.ref_req = 1; bus.out_req = 1;
    to_neg();
    chk("t8_rr_ref_after_rst", {bus.ref_gnt, bus.out_gnt}, 2'b10);
    tick();
    bus.ref_req = 0; bus.out_req = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
